// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce and a valid/ready key-event port.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES   = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] RowIn,
  output logic [3:0] ColOut,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Rows need two synchronizer cycles before the settle window ends.
  if (SETTLE_CYCLES < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scan_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [3:0]       sync1, rs;
  logic [1:0]       col, col_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]       pattern, pattern_next;
  logic [1:0]       row_idx, row_idx_next;
  logic             emit_c;
  logic             rep_fire_c;
  logic             one_low_c;
  logic [1:0]       low_idx_c;

  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // Exactly-one-low-row detection and its row index.
  always_comb begin
    one_low_c = 1'b0;
    low_idx_c = 2'd0;
    case (rs)
      4'b1110: begin one_low_c = 1'b1; low_idx_c = 2'd0; end
      4'b1101: begin one_low_c = 1'b1; low_idx_c = 2'd1; end
      4'b1011: begin one_low_c = 1'b1; low_idx_c = 2'd2; end
      4'b0111: begin one_low_c = 1'b1; low_idx_c = 2'd3; end
      default: begin one_low_c = 1'b0; low_idx_c = 2'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) state <= SCAN;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    col_next     = col;
    cnt_next     = cnt;
    pattern_next = pattern;
    row_idx_next = row_idx;
    emit_c       = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SETTLE_LAST) begin
          cnt_next = '0;
          if (one_low_c) begin
            state_next   = DEBOUNCE;
            pattern_next = rs;
            row_idx_next = low_idx_c;
          end else begin
            col_next = col + 2'd1;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DEBOUNCE: begin
        if (rs != pattern) begin
          state_next = SCAN;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = EMIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      EMIT: begin
        emit_c     = 1'b1;
        state_next = HOLD;
        cnt_next   = '0;
      end
      HOLD: begin
        // Release count only advances while every row reads high.
        if (rs != 4'hF) begin
          cnt_next = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = SCAN;
          col_next   = 2'd0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = SCAN;
        col_next   = 2'd0;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_next;

  // Repeat timer runs only while the latched key pattern is still present in HOLD.
  always_comb begin
    rep_cnt_next = '0;
    rep_fire_c   = 1'b0;
    if (state == HOLD && rs == pattern) begin
      if (rep_cnt == REP_LAST) begin
        rep_fire_c = 1'b1;
      end else if (rep_cnt != {REP_W{1'b1}}) begin
        rep_cnt_next = rep_cnt + REP_W'(1);
      end else begin
        rep_cnt_next = rep_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) rep_cnt <= '0;
    else     rep_cnt <= rep_cnt_next;
  end
`else
  assign rep_fire_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1     <= 4'hF;
      rs        <= 4'hF;
      col       <= 2'd0;
      cnt       <= '0;
      pattern   <= 4'hF;
      row_idx   <= 2'd0;
      ColOut    <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1    <= RowIn;
      rs       <= sync1;
      col      <= col_next;
      cnt      <= cnt_next;
      pattern  <= pattern_next;
      row_idx  <= row_idx_next;
      ColOut   <= ~(4'b0001 << col_next);
      key_held <= (state_next == HOLD);
      // A same-cycle acceptance frees the slot, so a new event never counts as overrun then.
      if (emit_c || rep_fire_c) begin
        if (!key_valid || key_ready) begin
          key_code  <= {row_idx, col};
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a combinational keypad matrix model.
module tb_keypad_scan_ctrl;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned DEB    = 8;
  localparam int unsigned REP    = 40;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int EXP_HOLD_EVENTS = 3;
`else
  localparam int EXP_HOLD_EVENTS = 1;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int ev_cnt = 0;
  int vhigh_cnt = 0;
  logic [3:0] ev_code = 4'h0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .RowIn    (RowIn),
    .ColOut   (ColOut),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overrun  (overrun)
  );

  // Keypad matrix: key r*4+c pulls row r low while column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) RowIn[r] = ~|(keys[r*4 +: 4] & ~ColOut);
  end

  // Counts accepted events and cycles with key_valid high.
  always @(posedge clk) begin
    if (!RST && key_valid) begin
      vhigh_cnt <= vhigh_cnt + 1;
      if (key_ready) begin
        ev_cnt  <= ev_cnt + 1;
        ev_code <= key_code;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n = 0;
    while (!key_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_valid), 32'd1);
  endtask

  task automatic wait_held(input logic val, input int max_cycles, input string tag);
    int n = 0;
    while (key_held !== val && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_held), 32'(val));
  endtask

  task automatic wait_col(input logic [3:0] target, input int max_cycles, input string tag);
    int n = 0;
    while (ColOut !== target && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ColOut), 32'(target));
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_col;
    logic [3:0] seen;
    logic       held_any;
    int         v0;
    int         e0;

    one = 4'b0001;
    RST = 1'b1;
    keys = 16'h0;
    key_ready = 1'b1;

    // 1: reset values and free-running column scan
    step(2);
    check("rst_col", 32'(ColOut), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    RST = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_col = ~(one << ((i / 4) % 4));
      check("scan_col", 32'(ColOut), 32'(exp_col));
      step(1);
    end

    // 2: key 9 held from reset; exact press-to-valid latency and release debounce
    RST = 1'b1;
    keys[9] = 1'b1;
    step(1);
    RST = 1'b0;
    step(16);
    check("k9_valid_early", 32'(key_valid), 32'h0);
    check("k9_held_early", 32'(key_held), 32'h0);
    step(1);
    check("k9_valid", 32'(key_valid), 32'h1);
    check("k9_code", 32'(key_code), 32'h9);
    check("k9_held", 32'(key_held), 32'h1);
    step(1);
    check("k9_valid_clr", 32'(key_valid), 32'h0);
    check("k9_ev", 32'(ev_cnt), 32'd1);
    step(10);
    check("k9_held_hold", 32'(key_held), 32'h1);
    keys = 16'h0;
    step(9);
    check("k9_held_rel9", 32'(key_held), 32'h1);
    step(1);
    check("k9_held_rel10", 32'(key_held), 32'h0);
    step(30);
    check("k9_ev_once", 32'(ev_cnt), 32'd1);
    check("k9_ev_code", 32'(ev_code), 32'h9);

    // 3: bouncing key 0 yields nothing, then a stable press yields code 0
    v0 = vhigh_cnt;
    for (int i = 0; i < 20; i++) begin
      keys[0] = ~keys[0];
      step(3);
    end
    check("bounce_novalid", 32'(vhigh_cnt), 32'(v0));
    keys[0] = 1'b1;
    wait_valid(80, "bounce_wait_valid");
    check("bounce_code", 32'(key_code), 32'h0);
    keys = 16'h0;
    wait_held(1'b0, 40, "bounce_release");
    check("bounce_ev", 32'(ev_cnt), 32'd2);

    // 4: pending code 5 survives a second press; overrun is raised
    key_ready = 1'b0;
    keys[5] = 1'b1;
    wait_valid(80, "ovr_wait_k5");
    check("ovr_code5", 32'(key_code), 32'h5);
    check("ovr_clear", 32'(overrun), 32'h0);
    keys = 16'h0;
    wait_held(1'b0, 40, "ovr_rel_k5");
    keys[10] = 1'b1;
    wait_held(1'b1, 80, "ovr_wait_kA");
    check("ovr_valid", 32'(key_valid), 32'h1);
    check("ovr_code_kept", 32'(key_code), 32'h5);
    check("ovr_set", 32'(overrun), 32'h1);
    key_ready = 1'b1;
    step(1);
    check("ovr_valid_clr", 32'(key_valid), 32'h0);
    check("ovr_ev_code", 32'(ev_code), 32'h5);
    keys = 16'h0;
    wait_held(1'b0, 40, "ovr_rel_kA");

    // 5a: two rows on column 2 are ignored and scanning continues
    v0 = vhigh_cnt;
    keys[2] = 1'b1;
    keys[14] = 1'b1;
    seen = 4'h0;
    held_any = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      seen = seen | ~ColOut;
      held_any = held_any | key_held;
    end
    check("multi_scan", 32'(seen), 32'hF);
    check("multi_noheld", 32'(held_any), 32'h0);
    check("multi_novalid", 32'(vhigh_cnt), 32'(v0));
    keys = 16'h0;

    // 5b: reset in the middle of debouncing key 0
    wait_col(4'b0111, 40, "mid_wait_c3");
    keys[0] = 1'b1;
    wait_col(4'b1110, 40, "mid_wait_c0");
    step(7);
    RST = 1'b1;
    step(1);
    check("mid_rst_col", 32'(ColOut), 32'hE);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_held", 32'(key_held), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    keys = 16'h0;
    e0 = ev_cnt;
    step(1);
    RST = 1'b0;
    step(40);
    check("mid_rst_noevent", 32'(vhigh_cnt), 32'(v0));
    check("mid_rst_noack", 32'(ev_cnt), 32'(e0));

    // 6: key F held for 100 cycles past acceptance
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    keys[15] = 1'b1;
    wait_valid(80, "hold_wait_kF");
    e0 = ev_cnt;
    step(100);
    check("hold_events", 32'(ev_cnt - e0), 32'(EXP_HOLD_EVENTS));
    check("hold_code", 32'(ev_code), 32'hF);
    keys = 16'h0;
    wait_held(1'b0, 40, "hold_release");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
